// File: rtl/bht_update_if.sv
// Execute-to-BHT update bus: resolved-branch outcomes in, one BHT update per cycle out.
// The master drives execute outcomes and observes updates; the slave is the queue.
interface bht_update_if;
    logic        exe_valid;
    logic [31:0] exe_pc;
    logic [31:0] exe_target;
    logic        exe_taken;
    logic        bht_is_write;
    logic [31:0] bht_executed_pc;
    logic [31:0] bht_dest_pc;
    logic        bht_is_taken;

    modport master (
        output exe_valid, exe_pc, exe_target, exe_taken,
        input  bht_is_write, bht_executed_pc, bht_dest_pc, bht_is_taken
    );

    modport slave (
        input  exe_valid, exe_pc, exe_target, exe_taken,
        output bht_is_write, bht_executed_pc, bht_dest_pc, bht_is_taken
    );
endinterface

// File: rtl/bht_update_queue.sv
// Buffers resolved-branch outcomes and drains them into the BHT one per cycle,
// after sequencing the BHT's post-reset table-clear window.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_INIT | BHT clear in progress: bht_resetn low, no pops, pushes kept
// S_RUN  | BHT live: head entry presented and retired every cycle
module bht_update_queue #(
    parameter int          DEPTH       = 4,
    parameter int          INIT_CYCLES = 32,
    parameter logic [31:0] IDLE_PC     = 32'hFFFF_FFFC
) (
    input  logic                     clk,
    input  logic                     reset,
    bht_update_if.slave              upd,
    output logic                     bht_resetn,
    output logic                     init_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              overflow_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  init_cnt;
    logic [PW-1:0]  head_ptr, tail_ptr;
    logic [31:0]    mem_pc     [DEPTH];
    logic [31:0]    mem_target [DEPTH];
    logic           mem_taken  [DEPTH];
    logic           push, pop, full;

    assign push = upd.exe_valid;
    assign full = (count == FULL_CNT);

    always_ff @(posedge clk) begin
        if (reset) state <= S_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_cnt == INIT_LAST) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        bht_resetn          = (state == S_RUN);
        init_done           = (state == S_RUN);
        pop                 = (state == S_RUN) && (count != '0);
        upd.bht_is_write    = 1'b0;
        upd.bht_executed_pc = IDLE_PC;
        upd.bht_dest_pc     = 32'h0;
        upd.bht_is_taken    = 1'b0;
        if (pop) begin
            upd.bht_is_write    = 1'b1;
            upd.bht_executed_pc = mem_pc[head_ptr];
            upd.bht_dest_pc     = mem_target[head_ptr];
            upd.bht_is_taken    = mem_taken[head_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                init_cnt <= '0;
        else if (state == S_INIT) init_cnt <= init_cnt + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail_ptr]     <= upd.exe_pc;
            mem_target[tail_ptr] <= upd.exe_target;
            mem_taken[tail_ptr]  <= upd.exe_taken;
        end
    end

    // A push into a full queue with no pop evicts the head: updates are only hints.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr     <= '0;
            tail_ptr     <= '0;
            count        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push)
                tail_ptr <= tail_ptr + PW'(1);
            if (pop || (push && full))
                head_ptr <= head_ptr + PW'(1);
            case ({push, pop})
                2'b10: begin
                    if (!full)
                        count <= count + CW'(1);
                    else if (overflow_cnt != 16'hFFFF)
                        overflow_cnt <= overflow_cnt + 16'd1;
                end
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_bht_update_queue.sv
// Self-checking bench for bht_update_queue: directed scenarios plus random traffic
// compared against a queue-based model of the update stream.
module tb_bht_update_queue;
    localparam int          DEPTH       = 4;
    localparam int          INIT_CYCLES = 32;
    localparam logic [31:0] IDLE_PC     = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        bht_resetn;
    logic        init_done;
    logic [2:0]  count;
    logic [15:0] overflow_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t mq[$];
    int   m_cyc = 0;
    int   m_ovf = 0;

    always #5 clk = ~clk;

    bht_update_if u ();

    bht_update_queue #(
        .DEPTH(DEPTH), .INIT_CYCLES(INIT_CYCLES), .IDLE_PC(IDLE_PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .upd(u.slave),
        .bht_resetn(bht_resetn),
        .init_done(init_done),
        .count(count),
        .overflow_cnt(overflow_cnt)
    );

    // One clock: drive inputs, let the edge happen, advance the model, settle at negedge.
    task automatic cycle(input logic rst, input logic v, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic tk);
        reset        = rst;
        u.exe_valid  = v;
        u.exe_pc     = pc;
        u.exe_target = tgt;
        u.exe_taken  = tk;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_cyc = 0;
            m_ovf = 0;
        end else begin
            if (m_cyc >= INIT_CYCLES && mq.size() > 0)
                mq.delete(0);
            if (v) begin
                if (mq.size() == DEPTH) begin
                    mq.delete(0);
                    if (m_ovf < 65535) m_ovf++;
                end
                mq.push_back('{pc, tgt, tk});
            end
            if (m_cyc < 1000000) m_cyc++;
        end
        @(negedge clk);
        u.exe_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    function automatic logic [86:0] m_exp();
        logic run;
        run = (m_cyc >= INIT_CYCLES);
        if (run && mq.size() > 0)
            return {1'b1, mq[0].pc, mq[0].tgt, mq[0].tk, run, run, 3'(mq.size()), 16'(m_ovf)};
        return {1'b0, IDLE_PC, 32'h0, 1'b0, run, run, 3'(mq.size()), 16'(m_ovf)};
    endfunction

    function automatic logic [86:0] dut_obs();
        return {u.bht_is_write, u.bht_executed_pc, u.bht_dest_pc, u.bht_is_taken,
                bht_resetn, init_done, count, overflow_cnt};
    endfunction

    task automatic test_reset();
        logic [86:0] rst_vec;
        rst_vec = {1'b0, IDLE_PC, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0};
        cycle(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        cycle(1'b1, 1'b1, 32'h1111_0000, 32'h2222_0000, 1'b1);
        n_checks++;
        if (dut_obs() !== rst_vec) begin
            n_fail++;
            $display("FAIL reset_values got=%h exp=%h", dut_obs(), rst_vec);
        end
    endtask

    task automatic test_init_window();
        logic exp_run;
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int c = 0; c <= 40; c++) begin
            exp_run = (c >= INIT_CYCLES);
            n_checks++;
            if (bht_resetn !== exp_run || init_done !== exp_run) begin
                n_fail++;
                $display("FAIL init_window cyc%0d resetn=%b init_done=%b exp=%b",
                         c, bht_resetn, init_done, exp_run);
            end
            n_checks++;
            if (u.bht_executed_pc !== IDLE_PC || u.bht_is_write !== 1'b0) begin
                n_fail++;
                $display("FAIL init_idle cyc%0d pc=%h wr=%b exp pc=%h wr=0",
                         c, u.bht_executed_pc, u.bht_is_write, IDLE_PC);
            end
            if (c < 40) idle(1);
        end
    endtask

    task automatic test_single();
        cycle(1'b0, 1'b1, 32'hBFC0_0010, 32'hBFC0_0100, 1'b1);
        n_checks++;
        if ({u.bht_is_write, u.bht_executed_pc, u.bht_dest_pc, u.bht_is_taken} !==
            {1'b1, 32'hBFC0_0010, 32'hBFC0_0100, 1'b1}) begin
            n_fail++;
            $display("FAIL single_present got wr=%b pc=%h dst=%h tk=%b exp wr=1 pc=bfc00010 dst=bfc00100 tk=1",
                     u.bht_is_write, u.bht_executed_pc, u.bht_dest_pc, u.bht_is_taken);
        end
        idle(1);
        n_checks++;
        if (u.bht_is_write !== 1'b0 || count !== 3'd0 || u.bht_executed_pc !== IDLE_PC) begin
            n_fail++;
            $display("FAIL single_retire got wr=%b cnt=%0d pc=%h exp wr=0 cnt=0 pc=%h",
                     u.bht_is_write, count, u.bht_executed_pc, IDLE_PC);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, pcs[i], pcs[i] + 32'h40, 1'(i));
            n_checks++;
            if (u.bht_is_write !== 1'b1 || u.bht_executed_pc !== pcs[i] ||
                u.bht_dest_pc !== pcs[i] + 32'h40 || count > 3'd1) begin
                n_fail++;
                $display("FAIL b2b_%0d got wr=%b pc=%h dst=%h cnt=%0d exp wr=1 pc=%h dst=%h cnt<=1",
                         i, u.bht_is_write, u.bht_executed_pc, u.bht_dest_pc, count,
                         pcs[i], pcs[i] + 32'h40);
            end
        end
        idle(1);
        n_checks++;
        if (u.bht_is_write !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_drain got wr=%b cnt=%0d exp wr=0 cnt=0", u.bht_is_write, count);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc;
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b1, 32'h10 + 32'(4 * i), 32'h1010 + 32'(4 * i), 1'(i));
        n_checks++;
        if (overflow_cnt !== 16'd2 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_counts got ovf=%0d cnt=%0d exp ovf=2 cnt=4", overflow_cnt, count);
        end
        idle(INIT_CYCLES - 6);
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'h18 + 32'(4 * k);
            n_checks++;
            if (u.bht_is_write !== 1'b1 || u.bht_executed_pc !== exp_pc ||
                u.bht_dest_pc !== exp_pc + 32'h1000) begin
                n_fail++;
                $display("FAIL ovf_drain_%0d got wr=%b pc=%h dst=%h exp wr=1 pc=%h dst=%h",
                         k, u.bht_is_write, u.bht_executed_pc, u.bht_dest_pc,
                         exp_pc, exp_pc + 32'h1000);
            end
            idle(1);
        end
        n_checks++;
        if (u.bht_is_write !== 1'b0 || count !== 3'd0 || overflow_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL ovf_empty got wr=%b cnt=%0d ovf=%0d exp wr=0 cnt=0 ovf=2",
                     u.bht_is_write, count, overflow_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 32'h500 + 32'(4 * i), 32'h600, 1'b0);
        idle(INIT_CYCLES - 4 + 1);
        n_checks++;
        if (u.bht_is_write !== 1'b1 || u.bht_executed_pc !== 32'h504 || count !== 3'd3) begin
            n_fail++;
            $display("FAIL rstmid_pre got wr=%b pc=%h cnt=%0d exp wr=1 pc=504 cnt=3",
                     u.bht_is_write, u.bht_executed_pc, count);
        end
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (count !== 3'd0 || u.bht_is_write !== 1'b0 || bht_resetn !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after got cnt=%0d wr=%b resetn=%b exp cnt=0 wr=0 resetn=0",
                     count, u.bht_is_write, bht_resetn);
        end
        bad = 0;
        for (int c = 1; c < INIT_CYCLES; c++) begin
            idle(1);
            if (bht_resetn !== 1'b0 || u.bht_is_write !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rstmid_window got %0d bad cycles exp 0", bad);
        end
        idle(1);
        n_checks++;
        if (bht_resetn !== 1'b1 || u.bht_is_write !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_run got resetn=%b wr=%b cnt=%0d exp resetn=1 wr=0 cnt=0",
                     bht_resetn, u.bht_is_write, count);
        end
    endtask

    task automatic test_init_run_edge();
        logic [31:0] order [4];
        order[0] = 32'h208; order[1] = 32'h20C; order[2] = 32'h300; order[3] = 32'h304;
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 32'h200 + 32'(4 * i), 32'h700, 1'b1);
        idle(INIT_CYCLES - 1 - 4);
        n_checks++;
        if (count !== 3'd4 || overflow_cnt !== 16'd0 || bht_resetn !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_pre got cnt=%0d ovf=%0d resetn=%b exp cnt=4 ovf=0 resetn=0",
                     count, overflow_cnt, bht_resetn);
        end
        cycle(1'b0, 1'b1, 32'h300, 32'h700, 1'b1);
        n_checks++;
        if (overflow_cnt !== 16'd1 || count !== 3'd4 || u.bht_executed_pc !== 32'h204) begin
            n_fail++;
            $display("FAIL edge_init_drop got ovf=%0d cnt=%0d pc=%h exp ovf=1 cnt=4 pc=204",
                     overflow_cnt, count, u.bht_executed_pc);
        end
        cycle(1'b0, 1'b1, 32'h304, 32'h700, 1'b1);
        n_checks++;
        if (overflow_cnt !== 16'd1 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL edge_run_nodrop got ovf=%0d cnt=%0d exp ovf=1 cnt=4", overflow_cnt, count);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (u.bht_is_write !== 1'b1 || u.bht_executed_pc !== order[k]) begin
                n_fail++;
                $display("FAIL edge_drain_%0d got wr=%b pc=%h exp wr=1 pc=%h",
                         k, u.bht_is_write, u.bht_executed_pc, order[k]);
            end
            idle(1);
        end
    endtask

    task automatic test_random();
        logic rst, v;
        int   errs;
        errs = 0;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            v   = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            cycle(rst, v, $urandom, $urandom, 1'($urandom));
            n_checks++;
            if (dut_obs() !== m_exp()) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cyc%0d got=%h exp=%h", i, dut_obs(), m_exp());
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        u.exe_valid  = 1'b0;
        u.exe_pc     = 32'h0;
        u.exe_target = 32'h0;
        u.exe_taken  = 1'b0;
        test_reset();
        test_init_window();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_init_run_edge();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
